// File: rtl/dcp_pkg.sv
// Shared constants and FSM encoding for the dark-channel row-minimum stage.
// The top and the channel-minimum sub-module take their default widths from here.
package dcp_pkg;

    localparam int DW = 8;
    localparam logic [DW-1:0] PIX_ONES = {DW{1'b1}};

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/rgb_min3.sv
// Purely combinational unsigned minimum of three samples.
// Reduces one RGB pixel to its darkest channel.
module rgb_min3 #(
    parameter int DW = dcp_pkg::DW
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    output logic [DW-1:0] min_o
);

    logic [DW-1:0] ab_min;

    always_comb begin
        ab_min = (a_i < b_i) ? a_i : b_i;
        min_o  = (ab_min < c_i) ? ab_min : c_i;
    end

endmodule

// File: rtl/dark_channel_row_min.sv
// Streaming per-row dark channel: min(R,G,B) per pixel, then the minimum over a
// centred WIN-pixel horizontal window truncated at the line edges.
module dark_channel_row_min #(
    parameter int DW  = dcp_pkg::DW,
    parameter int WIN = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    input  logic          in_sol,
    input  logic          in_eol,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_dark,
    output logic          out_sol,
    output logic          out_eol
);

    import dcp_pkg::state_t;
    import dcp_pkg::RUN;
    import dcp_pkg::FLUSH;

    localparam int HALF = (WIN - 1) / 2;
    localparam int FCW  = $clog2(HALF + 1);
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    typedef struct packed {
        logic [DW-1:0] val;
        logic          vld;
        logic          sol;
        logic          eol;
    } entry_t;

    // An empty slot carries all-ones so it is neutral for the minimum.
    localparam entry_t EMPTY = '{val: ONES, vld: 1'b0, sol: 1'b0, eol: 1'b0};

    entry_t         win_q [WIN];
    entry_t         win_d [WIN];
    entry_t         head_e;
    state_t         state_q, state_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_dark_q, out_dark_d;
    logic           out_sol_q, out_sol_d;
    logic           out_eol_q, out_eol_d;

    logic [DW-1:0]  pix_min;
    logic [DW-1:0]  win_min;
    logic           adv;
    logic           accept;
    logic           flush_shift;
    logic           shift;

    rgb_min3 #(.DW(DW)) u_rgb_min3 (
        .a_i   (in_r),
        .b_i   (in_g),
        .c_i   (in_b),
        .min_o (pix_min)
    );

    // A stalled output register freezes the whole stage, including the window.
    assign adv         = !out_valid_q || out_ready;
    assign in_ready    = adv && (state_q == RUN) && !rst;
    assign accept      = in_valid && in_ready;
    assign flush_shift = adv && (state_q == FLUSH);
    assign shift       = accept || flush_shift;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_e = EMPTY;
        if (accept) begin
            head_e = '{val: pix_min, vld: 1'b1, sol: in_sol, eol: in_eol};
        end

        for (int k = 0; k < WIN; k++) begin
            win_d[k] = win_q[k];
        end

        if (shift) begin
            win_d[0] = head_e;
            for (int k = 1; k < WIN; k++) begin
                // A new line start discards everything left from the previous line.
                win_d[k] = (accept && in_sol) ? EMPTY : win_q[k-1];
            end
        end
    end

    always_comb begin
        win_min = ONES;
        for (int k = 0; k < WIN; k++) begin
            if (win_d[k].vld && (win_d[k].val < win_min)) begin
                win_min = win_d[k].val;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_dark_d  = out_dark_q;
        out_sol_d   = out_sol_q;
        out_eol_d   = out_eol_q;
        if (adv) begin
            out_valid_d = shift && win_d[HALF].vld;
            if (shift) begin
                out_dark_d = win_min;
                out_sol_d  = win_d[HALF].sol;
                out_eol_d  = win_d[HALF].eol;
            end
        end
    end

    // After the last pixel, HALF empty entries push the line tail through the centre.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        unique case (state_q)
            RUN: begin
                if (accept && in_eol) begin
                    state_d = FLUSH;
                    fc_d    = FCW'(HALF);
                end
            end
            FLUSH: begin
                if (adv) begin
                    fc_d = fc_q - FCW'(1);
                    if (fc_q == FCW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
                fc_d    = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the window is a
    // register array, so it is cleared on reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WIN; k++) begin
                win_q[k] <= EMPTY;
            end
            state_q     <= RUN;
            fc_q        <= '0;
            out_valid_q <= 1'b0;
            out_dark_q  <= '0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            win_q       <= win_d;
            state_q     <= state_d;
            fc_q        <= fc_d;
            out_valid_q <= out_valid_d;
            out_dark_q  <= out_dark_d;
            out_sol_q   <= out_sol_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dark  = out_dark_q;
    assign out_sol   = out_sol_q;
    assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_dark_channel_row_min.sv
// Self-checking bench: a WIN=3 and a WIN=15 instance driven with directed and
// random lines, compared against a per-line truncated-window minimum model.
module tb_dark_channel_row_min;

    localparam int DW   = 8;
    localparam int WIN0 = 3;
    localparam int WIN1 = 15;
    localparam int ACCEPT_LIMIT = 300;
    localparam int DRAIN_LIMIT  = 3000;

    typedef struct packed {
        logic [7:0] v;
        logic       s;
        logic       e;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_r      [2];
    logic [DW-1:0] in_g      [2];
    logic [DW-1:0] in_b      [2];
    logic          in_sol    [2];
    logic          in_eol    [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_dark  [2];
    logic          out_sol   [2];
    logic          out_eol   [2];

    bit   rdy_force [2] = '{1'b1, 1'b1};
    bit   rdy_rand  [2] = '{1'b0, 1'b0};
    obs_t got_q [2][$];
    obs_t exp_q [2][$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dark_channel_row_min #(.DW(DW), .WIN(WIN0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_r      (in_r[0]),
        .in_g      (in_g[0]),
        .in_b      (in_b[0]),
        .in_sol    (in_sol[0]),
        .in_eol    (in_eol[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_dark  (out_dark[0]),
        .out_sol   (out_sol[0]),
        .out_eol   (out_eol[0])
    );

    dark_channel_row_min #(.DW(DW), .WIN(WIN1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_r      (in_r[1]),
        .in_g      (in_g[1]),
        .in_b      (in_b[1]),
        .in_sol    (in_sol[1]),
        .in_eol    (in_eol[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_dark  (out_dark[1]),
        .out_sol   (out_sol[1]),
        .out_eol   (out_eol[1])
    );

    // Downstream ready: applied 2 time units after each rising edge.
    initial begin
        for (int i = 0; i < 2; i++) out_ready[i] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                out_ready[i] = rdy_rand[i] ? ($urandom_range(0, 3) != 0) : rdy_force[i];
            end
        end
    end

    // Output monitor: a transfer happens at the next rising edge when valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst && out_valid[i] && out_ready[i]) begin
                    got_q[i].push_back('{v: out_dark[i], s: out_sol[i], e: out_eol[i]});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int win_of(input int s);
        return (s == 0) ? WIN0 : WIN1;
    endfunction

    // Minimum over the centred window around pixel i, clipped to the line.
    function automatic logic [7:0] win_ref(input logic [7:0] px[$], input int i, input int win);
        int         h;
        logic [7:0] m;
        h = (win - 1) / 2;
        m = 8'hFF;
        for (int j = i - h; j <= i + h; j++) begin
            if (j >= 0 && j < px.size()) begin
                if (px[j] < m) m = px[j];
            end
        end
        return m;
    endfunction

    task automatic model_line(input int s, input logic [7:0] px[$]);
        for (int i = 0; i < px.size(); i++) begin
            exp_q[s].push_back('{v: win_ref(px, i, win_of(s)), s: (i == 0), e: (i == px.size() - 1)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_pix(input int s, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic sol, input logic eol);
        int waited;
        waited      = 0;
        in_valid[s] = 1'b1;
        in_r[s]     = r;
        in_g[s]     = g;
        in_b[s]     = b;
        in_sol[s]   = sol;
        in_eol[s]   = eol;
        @(negedge clk);
        while (!in_ready[s] && waited < ACCEPT_LIMIT) begin
            waited++;
            @(negedge clk);
        end
        check("accept_wait", (waited < ACCEPT_LIMIT), 1);
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
    endtask

    task automatic send_val(input int s, input logic [7:0] v, input logic sol, input logic eol);
        logic [7:0] c [3];
        int         pick;
        pick = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) begin
            c[k] = (k == pick) ? v : 8'(int'(v) + $urandom_range(0, 255 - int'(v)));
        end
        send_pix(s, c[0], c[1], c[2], sol, eol);
    endtask

    task automatic send_line(input int s, input logic [7:0] px[$], input bit gaps);
        for (int i = 0; i < px.size(); i++) begin
            send_val(s, px[i], (i == 0), (i == px.size() - 1));
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    // Wait for all expected outputs, allow time for extras, then compare in order.
    task automatic drain(input int s, input string tag);
        int n;
        n = 0;
        while (got_q[s].size() < exp_q[s].size() && n < DRAIN_LIMIT) begin
            n++;
            @(negedge clk);
        end
        repeat (24) @(negedge clk);
        check({tag, "_count"}, got_q[s].size(), exp_q[s].size());
        for (int i = 0; i < exp_q[s].size() && i < got_q[s].size(); i++) begin
            check($sformatf("%s_out%0d", tag, i), 32'(got_q[s][i]), 32'(exp_q[s][i]));
        end
        got_q[s].delete();
        exp_q[s].delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] px [$];
        int         n;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_r[i]     = '0;
            in_g[i]     = '0;
            in_b[i]     = '0;
            in_sol[i]   = 1'b0;
            in_eol[i]   = 1'b0;
        end
        in_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
            check($sformatf("rst_out_dark%0d", i), out_dark[i], 0);
            check($sformatf("rst_out_sol%0d", i), out_sol[i], 0);
            check($sformatf("rst_out_eol%0d", i), out_eol[i], 0);
            check($sformatf("rst_in_ready%0d", i), in_ready[i], 0);
        end
        in_valid[0] = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic line on WIN=3.
        px = '{8'd50, 8'd20, 8'd80, 8'd90};
        model_line(0, px);
        send_line(0, px, 1'b0);
        drain(0, "t1");

        // Single-pixel line; one flush cycle with in_ready low.
        exp_q[0].push_back('{v: 8'd30, s: 1'b1, e: 1'b1});
        send_pix(0, 8'd200, 8'd30, 8'd90, 1'b1, 1'b1);
        @(negedge clk);
        check("t2_in_ready_flush", in_ready[0], 0);
        @(negedge clk);
        check("t2_in_ready_run", in_ready[0], 1);
        drain(0, "t2");

        // Back-to-back lines must not mix.
        px = '{8'd10};
        model_line(0, px);
        send_line(0, px, 1'b0);
        px = '{8'd200, 8'd210};
        model_line(0, px);
        send_line(0, px, 1'b0);
        drain(0, "t3");

        // Downstream stall mid-line.
        px = '{8'd60, 8'd40, 8'd70, 8'd30, 8'd90, 8'd55};
        model_line(0, px);
        send_val(0, px[0], 1'b1, 1'b0);
        send_val(0, px[1], 1'b0, 1'b0);
        send_val(0, px[2], 1'b0, 1'b0);
        rdy_force[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_r[0]      = px[3];
        in_g[0]      = px[3];
        in_b[0]      = px[3];
        in_sol[0]    = 1'b0;
        in_eol[0]    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4_stall_valid%0d", c), out_valid[0], 1);
            check($sformatf("t4_stall_dark%0d", c), out_dark[0], win_ref(px, 1, WIN0));
            check($sformatf("t4_stall_in_ready%0d", c), in_ready[0], 0);
        end
        rdy_force[0] = 1'b1;
        @(posedge clk);
        #1;
        send_val(0, px[3], 1'b0, 1'b0);
        send_val(0, px[4], 1'b0, 1'b0);
        send_val(0, px[5], 1'b0, 1'b1);
        drain(0, "t4");

        // WIN=15 short line: 7 flush cycles.
        px = '{8'd9, 8'd7, 8'd5};
        model_line(1, px);
        send_line(1, px, 1'b0);
        n = 0;
        @(negedge clk);
        while (!in_ready[1] && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t5_flush_cycles", n, 7);
        drain(1, "t5");

        // Reset during flush discards the pending line.
        send_val(0, 8'd40, 1'b1, 1'b0);
        send_val(0, 8'd30, 1'b0, 1'b1);
        check("t6_pre_valid", out_valid[0], 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid[0], 0);
        check("t6_rst_out_dark", out_dark[0], 0);
        check("t6_rst_in_ready", in_ready[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        px = '{8'd100};
        model_line(0, px);
        send_line(0, px, 1'b0);
        drain(0, "t6");

        // Random lines with random backpressure and input gaps on both instances.
        for (int s = 0; s < 2; s++) begin
            rdy_rand[s] = 1'b1;
            for (int l = 0; l < 6; l++) begin
                px.delete();
                n = $urandom_range(1, (s == 0) ? 12 : 24);
                for (int i = 0; i < n; i++) px.push_back(8'($urandom_range(0, 255)));
                model_line(s, px);
                send_line(s, px, 1'b1);
            end
            drain(s, $sformatf("rand%0d", s));
            rdy_rand[s] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
